// File: rtl/analyst_frame_ctrl_if.sv
// Result bus between the frame sequencer and the RS232/VGA consumer.
// master: drives the snapshot and res_valid; slave: drives res_ready.
interface analyst_frame_ctrl_if;
   logic [11:0] res_centre_x;
   logic [11:0] res_centre_y;
   logic [9:0]  res_angle_x;
   logic [9:0]  res_angle_y;
   logic        res_dir;
   logic [18:0] res_obj_cnt;
   logic        res_found;
   logic        res_valid;
   logic        res_ready;

   modport master (
      output res_centre_x, res_centre_y,
      output res_angle_x, res_angle_y,
      output res_dir, res_obj_cnt,
      output res_found, res_valid,
      input  res_ready
   );

   modport slave (
      input  res_centre_x, res_centre_y,
      input  res_angle_x, res_angle_y,
      input  res_dir, res_obj_cnt,
      input  res_found, res_valid,
      output res_ready
   );
endinterface

// File: rtl/analyst_frame_ctrl.sv
// Frame sequencer for the extremal-point/centre/angle datapath.
// In: clk, rst, frame/pixel strobes, dp_* results. Out: new_frm, dp_enw,
// busy, ovr_cnt, err_cnt; snapshot offered on rb (valid/ready).
module analyst_frame_ctrl #(
   parameter int unsigned FRAME_DIV  = 1,
   parameter int unsigned MIN_PIX    = 16,
   parameter int unsigned SETTLE_CYC = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        frm_start,
   input  logic        frm_end,
   input  logic        pix_en,
   input  logic        pix_obj_n,
   output logic        new_frm,
   output logic        dp_enw,
   input  logic [11:0] dp_centre_x,
   input  logic [11:0] dp_centre_y,
   input  logic [9:0]  dp_angle_x,
   input  logic [9:0]  dp_angle_y,
   input  logic        dp_dir,
   analyst_frame_ctrl_if.master rb,
   output logic [7:0]  ovr_cnt,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   localparam logic [2:0] S_CLEAR  = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_ACCUM  = 3'd2;
   localparam logic [2:0] S_SKIP   = 3'd3;
   localparam logic [2:0] S_SETTLE = 3'd4;
   localparam logic [2:0] S_LATCH  = 3'd5;

   localparam logic [7:0]  DIV_LAST = 8'(FRAME_DIV - 1);
   localparam logic [3:0]  SET_LAST = 4'(SETTLE_CYC - 1);
   localparam logic [18:0] MIN_CNT  = 19'(MIN_PIX);

   logic [2:0]  state_q, state_d;
   logic [3:0]  sub_q, sub_d;
   logic [7:0]  div_q, div_d;
   logic [18:0] obj_q, obj_d;
   logic [7:0]  ovr_q, ovr_d;
   logic [7:0]  err_q, err_d;
   logic [11:0] cx_q, cx_d, cy_q, cy_d;
   logic [9:0]  ax_q, ax_d, ay_q, ay_d;
   logic        dir_q, dir_d;
   logic [18:0] cnt_q, cnt_d;
   logic        fnd_q, fnd_d;
   logic        vld_q, vld_d;

   logic       accept;
   logic       obj_hit;
   logic [7:0] div_nxt;

   assign accept  = vld_q & rb.res_ready;
   assign obj_hit = pix_en & ~pix_obj_n;
   assign div_nxt = (div_q == DIV_LAST) ? 8'd0 : div_q + 8'd1;

   always_comb begin
      state_d = state_q;
      sub_d   = sub_q;
      div_d   = div_q;
      obj_d   = obj_q;
      ovr_d   = ovr_q;
      err_d   = err_q;
      cx_d    = cx_q;
      cy_d    = cy_q;
      ax_d    = ax_q;
      ay_d    = ay_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      fnd_d   = fnd_q;
      vld_d   = accept ? 1'b0 : vld_q;

      case (state_q)
         S_CLEAR: begin
            if (sub_q == 4'd2) begin
               state_d = S_WAIT;
               sub_d   = 4'd0;
            end else begin
               sub_d = sub_q + 4'd1;
            end
         end
         S_WAIT: begin
            if (frm_start) begin
               div_d = div_nxt;
               if (div_q == 8'd0) begin
                  state_d = S_ACCUM;
                  obj_d   = 19'd0;
               end else begin
                  state_d = S_SKIP;
               end
            end
         end
         S_ACCUM: begin
            // A new frame start means frm_end was lost: drop this frame.
            if (frm_start) begin
               if (err_q != 8'hFF) err_d = err_q + 8'd1;
               state_d = S_CLEAR;
               sub_d   = 4'd0;
            end else begin
               if (obj_hit && obj_q != '1) obj_d = obj_q + 19'd1;
               if (frm_end) begin
                  state_d = S_SETTLE;
                  sub_d   = 4'd0;
               end
            end
         end
         S_SKIP: begin
            // A start while skipping is simply the next frame.
            if (frm_start) begin
               div_d = div_nxt;
               if (div_q == 8'd0) begin
                  state_d = S_ACCUM;
                  obj_d   = 19'd0;
               end else begin
                  state_d = S_SKIP;
               end
            end else if (frm_end) begin
               state_d = S_WAIT;
            end
         end
         S_SETTLE: begin
            if (sub_q == SET_LAST) begin
               state_d = S_LATCH;
               sub_d   = 4'd0;
            end else begin
               sub_d = sub_q + 4'd1;
            end
         end
         S_LATCH: begin
            cx_d  = dp_centre_x;
            cy_d  = dp_centre_y;
            ax_d  = dp_angle_x;
            ay_d  = dp_angle_y;
            dir_d = dp_dir;
            cnt_d = obj_q;
            fnd_d = (obj_q >= MIN_CNT);
            vld_d = 1'b1;
            // Same-cycle accept consumed the old snapshot: no overrun.
            if (vld_q && !rb.res_ready && ovr_q != 8'hFF)
               ovr_d = ovr_q + 8'd1;
            state_d = S_CLEAR;
            sub_d   = 4'd0;
         end
         default: begin
            state_d = S_CLEAR;
            sub_d   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CLEAR;
         sub_q   <= 4'd0;
         div_q   <= 8'd0;
         obj_q   <= 19'd0;
         ovr_q   <= 8'd0;
         err_q   <= 8'd0;
         cx_q    <= 12'd0;
         cy_q    <= 12'd0;
         ax_q    <= 10'd0;
         ay_q    <= 10'd0;
         dir_q   <= 1'b0;
         cnt_q   <= 19'd0;
         fnd_q   <= 1'b0;
         vld_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sub_q   <= sub_d;
         div_q   <= div_d;
         obj_q   <= obj_d;
         ovr_q   <= ovr_d;
         err_q   <= err_d;
         cx_q    <= cx_d;
         cy_q    <= cy_d;
         ax_q    <= ax_d;
         ay_q    <= ay_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         fnd_q   <= fnd_d;
         vld_q   <= vld_d;
      end
   end

   // Held low during reset so the two-cycle clear pulse always starts
   // on the first cycle after reset is released.
   assign new_frm = (state_q == S_CLEAR) & (sub_q < 4'd2) & ~rst;
   assign dp_enw  = (state_q == S_ACCUM) & pix_en;
   assign busy    = (state_q != S_WAIT);
   assign ovr_cnt = ovr_q;
   assign err_cnt = err_q;

   assign rb.res_centre_x = cx_q;
   assign rb.res_centre_y = cy_q;
   assign rb.res_angle_x  = ax_q;
   assign rb.res_angle_y  = ay_q;
   assign rb.res_dir      = dir_q;
   assign rb.res_obj_cnt  = cnt_q;
   assign rb.res_found    = fnd_q;
   assign rb.res_valid    = vld_q;

endmodule

// File: tb/tb_analyst_frame_ctrl.sv
// Self-checking bench for analyst_frame_ctrl (FRAME_DIV=1 and FRAME_DIV=3).
// Frame table + snapshot scoreboard, plus hand-written corner sequences.
module tb_analyst_frame_ctrl;

   typedef struct {
      int w; int h; int x0; int y0; int ow; int oh; int cnt; bit found;
   } vec_t;

   typedef struct {
      logic [18:0] cnt;
      logic        found;
      logic [11:0] cx;
      logic [11:0] cy;
      logic [9:0]  ax;
      logic [9:0]  ay;
      logic        dir;
   } snap_t;

   logic clk = 1'b0;
   logic rst;
   logic frm_start, frm_end, pix_en, pix_obj_n;
   logic [11:0] dp_cx, dp_cy;
   logic [9:0]  dp_ax, dp_ay;
   logic        dp_dir;

   logic       new_frm1, enw1_w, busy1;
   logic [7:0] ovr1, err1;
   logic       new_frm3, enw3_w, busy3;
   logic [7:0] ovr3, err3;

   analyst_frame_ctrl_if bus1 ();
   analyst_frame_ctrl_if bus3 ();

   analyst_frame_ctrl #(.FRAME_DIV(1), .MIN_PIX(16), .SETTLE_CYC(2)) dut1 (
      .clk(clk), .rst(rst),
      .frm_start(frm_start), .frm_end(frm_end),
      .pix_en(pix_en), .pix_obj_n(pix_obj_n),
      .new_frm(new_frm1), .dp_enw(enw1_w),
      .dp_centre_x(dp_cx), .dp_centre_y(dp_cy),
      .dp_angle_x(dp_ax), .dp_angle_y(dp_ay), .dp_dir(dp_dir),
      .rb(bus1), .ovr_cnt(ovr1), .err_cnt(err1), .busy(busy1)
   );

   analyst_frame_ctrl #(.FRAME_DIV(3), .MIN_PIX(16), .SETTLE_CYC(2)) dut3 (
      .clk(clk), .rst(rst),
      .frm_start(frm_start), .frm_end(frm_end),
      .pix_en(pix_en), .pix_obj_n(pix_obj_n),
      .new_frm(new_frm3), .dp_enw(enw3_w),
      .dp_centre_x(dp_cx), .dp_centre_y(dp_cy),
      .dp_angle_x(dp_ax), .dp_angle_y(dp_ay), .dp_dir(dp_dir),
      .rb(bus3), .ovr_cnt(ovr3), .err_cnt(err3), .busy(busy3)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int enw1 = 0;
   int enw3 = 0;
   int snap3 = 0;
   snap_t sbq[$];
   snap_t mon_e;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (enw1_w) enw1++;
      if (enw3_w) enw3++;
      if (bus3.res_valid && bus3.res_ready) snap3++;
   end

   // Scoreboard: every accepted snapshot must match the oldest expectation.
   always @(negedge clk) begin
      if (bus1.res_valid && bus1.res_ready) begin
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_empty: snapshot offered, none expected at %0t", $time);
         end else begin
            mon_e = sbq.pop_front();
            check("sb_obj_cnt", 32'(bus1.res_obj_cnt), 32'(mon_e.cnt));
            check("sb_found", 32'(bus1.res_found), 32'(mon_e.found));
            check("sb_centre_x", 32'(bus1.res_centre_x), 32'(mon_e.cx));
            check("sb_centre_y", 32'(bus1.res_centre_y), 32'(mon_e.cy));
            check("sb_angle_x", 32'(bus1.res_angle_x), 32'(mon_e.ax));
            check("sb_angle_y", 32'(bus1.res_angle_y), 32'(mon_e.ay));
            check("sb_dir", 32'(bus1.res_dir), 32'(mon_e.dir));
         end
      end
   end

   task automatic set_dp();
      dp_cx  = 12'($urandom);
      dp_cy  = 12'($urandom);
      dp_ax  = 10'($urandom);
      dp_ay  = 10'($urandom);
      dp_dir = 1'($urandom);
   endtask

   // Rst held for two edges, checked, then released; the CLEAR pulse is
   // checked and a stray frm_start is injected while clearing.
   task automatic do_reset(input bit chk);
      rst = 1'b1; frm_start = 1'b0; frm_end = 1'b0;
      pix_en = 1'b1; pix_obj_n = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(negedge clk);
      if (chk) begin
         check("rst_new_frm", 32'(new_frm1), 0);
         check("rst_dp_enw", 32'(enw1_w), 0);
         check("rst_busy", 32'(busy1), 1);
         check("rst_valid", 32'(bus1.res_valid), 0);
         check("rst_obj_cnt", 32'(bus1.res_obj_cnt), 0);
         check("rst_centre_x", 32'(bus1.res_centre_x), 0);
         check("rst_ovr", 32'(ovr1), 0);
         check("rst_err", 32'(err1), 0);
      end
      @(posedge clk); #1;
      rst = 1'b0; pix_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         frm_start = (k == 1);
         @(negedge clk);
         if (chk) begin
            check("clr_new_frm", 32'(new_frm1), (k < 2) ? 32'd1 : 32'd0);
            check("clr_new_frm3", 32'(new_frm3), (k < 2) ? 32'd1 : 32'd0);
            if (k == 3) check("clr_idle", 32'(busy1), 0);
         end
         if (k < 3) begin
            @(posedge clk); #1;
         end
      end
      frm_start = 1'b0;
   endtask

   task automatic send_frame(input vec_t v, input bit with_end);
      @(posedge clk); #1;
      frm_start = 1'b1; frm_end = 1'b0; pix_en = 1'b0;
      for (int y = 0; y < v.h; y++) begin
         for (int x = 0; x < v.w; x++) begin
            @(posedge clk); #1;
            frm_start = 1'b0;
            pix_en    = 1'b1;
            pix_obj_n = !(x >= v.x0 && x < v.x0 + v.ow &&
                          y >= v.y0 && y < v.y0 + v.oh);
            frm_end   = with_end && (x == v.w - 1) && (y == v.h - 1);
         end
      end
   endtask

   // One complete frame with an 8-cycle tail; dp_* change at frm_end,
   // again in SETTLE (the values LATCH must capture) and after LATCH.
   task automatic run_frame(input vec_t v, input bit lat_chk, input int an3,
                            input bit push, output snap_t s);
      int e1, e3;
      @(negedge clk);
      if (lat_chk) check("idle_busy", 32'(busy1), 0);
      e1 = enw1;
      e3 = enw3;
      send_frame(v, 1'b1);
      set_dp();
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         frm_end = 1'b0; pix_en = (k <= 2); pix_obj_n = 1'b0;
         if (k == 1) begin
            set_dp();
            s.cnt = 19'(v.cnt); s.found = v.found;
            s.cx = dp_cx; s.cy = dp_cy; s.ax = dp_ax; s.ay = dp_ay;
            s.dir = dp_dir;
            if (push) sbq.push_back(s);
         end
         if (k == 4) set_dp();
         @(negedge clk);
         if (lat_chk && k == 3) check("lat_early", 32'(bus1.res_valid), 0);
         if (lat_chk && k == 4) check("lat_valid", 32'(bus1.res_valid), 1);
      end
      pix_en = 1'b0;
      check("enw_cnt", 32'(enw1 - e1), 32'(v.w * v.h));
      if (an3 >= 0)
         check("enw3_cnt", 32'(enw3 - e3), (an3 != 0) ? 32'(v.w * v.h) : 32'd0);
   endtask

   vec_t  tbl[6];
   vec_t  vf;
   snap_t s, s3;
   int    n3;

   initial begin
      rst = 1'b1; frm_start = 1'b0; frm_end = 1'b0;
      pix_en = 1'b0; pix_obj_n = 1'b1;
      dp_cx = '0; dp_cy = '0; dp_ax = '0; dp_ay = '0; dp_dir = 1'b0;
      bus1.res_ready = 1'b1;
      bus3.res_ready = 1'b1;

      tbl[0] = '{64, 48, 10, 5, 20, 10, 200, 1'b1};
      tbl[1] = '{16, 8, 3, 2, 5, 1, 5, 1'b0};
      tbl[2] = '{16, 8, 0, 0, 4, 4, 16, 1'b1};
      tbl[3] = '{16, 8, 1, 7, 15, 1, 15, 1'b0};
      tbl[4] = '{16, 8, 0, 0, 0, 0, 0, 1'b0};
      tbl[5] = '{8, 4, 0, 0, 8, 4, 32, 1'b1};
      vf     = '{8, 4, 2, 1, 2, 2, 4, 1'b0};

      do_reset(1'b1);
      for (int i = 0; i < 6; i++) run_frame(tbl[i], 1'b1, -1, 1'b1, s);
      @(negedge clk);
      check("tbl_ovr", 32'(ovr1), 0);
      check("tbl_err", 32'(err1), 0);

      // Decimation: only frames 0 and 3 are analysed with FRAME_DIV=3.
      do_reset(1'b0);
      n3 = snap3;
      for (int i = 0; i < 6; i++)
         run_frame(vf, 1'b1, (i % 3 == 0) ? 1 : 0, 1'b1, s);
      check("div_snaps", 32'(snap3 - n3), 2);
      check("div_obj_cnt", 32'(bus3.res_obj_cnt), 4);
      check("div_ovr", 32'(ovr3), 0);
      check("div_err", 32'(err3), 0);
      check("div_idle", 32'(busy3), 0);

      // Overrun: three snapshots with nobody reading.
      do_reset(1'b0);
      bus1.res_ready = 1'b0;
      run_frame(tbl[1], 1'b0, -1, 1'b0, s);
      run_frame(tbl[2], 1'b0, -1, 1'b0, s);
      run_frame(tbl[3], 1'b0, -1, 1'b0, s3);
      check("ovr_cnt", 32'(ovr1), 2);
      check("ovr_valid", 32'(bus1.res_valid), 1);
      check("ovr_obj_cnt", 32'(bus1.res_obj_cnt), 32'(s3.cnt));
      check("ovr_centre_x", 32'(bus1.res_centre_x), 32'(s3.cx));
      check("ovr_angle_y", 32'(bus1.res_angle_y), 32'(s3.ay));
      sbq.push_back(s3);
      @(posedge clk); #1;
      bus1.res_ready = 1'b1;
      @(posedge clk); #1;
      bus1.res_ready = 1'b0;
      @(negedge clk);
      check("ovr_drop_valid", 32'(bus1.res_valid), 0);
      bus1.res_ready = 1'b1;

      // Abort: frame without frm_end, then frm_start and frm_end together.
      send_frame(tbl[1], 1'b0);
      @(posedge clk); #1;
      frm_start = 1'b1; frm_end = 1'b1; pix_en = 1'b1; pix_obj_n = 1'b0;
      @(posedge clk); #1;
      frm_start = 1'b0; frm_end = 1'b0; pix_en = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("abort_new_frm", 32'(new_frm1), (k <= 2) ? 32'd1 : 32'd0);
         check("abort_valid", 32'(bus1.res_valid), 0);
         if (k == 1) check("abort_err", 32'(err1), 1);
         if (k == 4) check("abort_idle", 32'(busy1), 0);
         if (k < 4) begin
            @(posedge clk); #1;
         end
      end
      run_frame(tbl[0], 1'b1, -1, 1'b1, s);

      // Reset during SETTLE with an unread snapshot pending.
      bus1.res_ready = 1'b0;
      run_frame(tbl[5], 1'b0, -1, 1'b0, s);
      check("pre_rst_valid", 32'(bus1.res_valid), 1);
      send_frame(tbl[4], 1'b1);
      @(posedge clk); #1;
      frm_end = 1'b0; pix_en = 1'b0;
      do_reset(1'b1);
      bus1.res_ready = 1'b1;
      run_frame(tbl[2], 1'b1, -1, 1'b1, s);

      @(negedge clk);
      check("sb_drained", 32'(sbq.size()), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
